// File: rtl/sipo_deserializer_with_ce_pkg.sv
// Shared definitions for the SIPO deserializer and its counter.
//   DEFAULT_WIDTH : word width shared with the downstream 4-bit PIPO register
//   cnt_width()   : bit-count width derivation, $clog2(width)
//   action_t      : per-edge action selected by the deserializer datapath
package sipo_deserializer_with_ce_pkg;

  localparam int DEFAULT_WIDTH = 4;

  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

  typedef enum logic [1:0] {
    ACT_CLEAR,
    ACT_HOLD,
    ACT_SHIFT,
    ACT_COMPLETE
  } action_t;

endpackage

// File: rtl/sipo_deserializer_with_ce_counter.sv
// Modulo-N bit counter for the deserializer.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   clr     : synchronous clear, overrides en
//   en      : advance the count
//   cnt     : current count, 0..N-1
//   wrap    : high when the coming edge takes cnt from N-1 back to 0
module mod_n_counter
  import sipo_deserializer_with_ce_pkg::*;
#(
  parameter int N = DEFAULT_WIDTH,
  localparam int CW = cnt_width(N)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          wrap
);

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  assign wrap = en & ~clr & (cnt == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/sipo_deserializer_with_ce.sv
// Serial-in, parallel-out deserializer with clock enable and frame clear.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   ce      : accept sin on this edge
//   clr     : synchronous frame restart, drops the partial word
//   sin     : serial data bit
//   q       : last completed word, held between completions
//   valid   : one-cycle strobe marking a new q
//   cnt     : bits held in the current partial word
module sipo_deserializer_with_ce
  import sipo_deserializer_with_ce_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MSB_FIRST = 1,
  localparam int CW = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ce,
  input  logic             clr,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             valid,
  output logic [CW-1:0]    cnt
);

  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] shifted;
  logic             wrap;
  action_t          act;

  mod_n_counter #(.N(WIDTH)) u_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clr),
    .en      (ce),
    .cnt     (cnt),
    .wrap    (wrap)
  );

  // The completed word is the shift result including this edge's sin,
  // so q is loaded straight from the shifter rather than from sh.
  always_comb begin
    shifted = sh;
    if (MSB_FIRST != 0) begin
      shifted = {sh[WIDTH-2:0], sin};
    end else begin
      shifted = {sin, sh[WIDTH-1:1]};
    end
  end

  always_comb begin
    act = ACT_HOLD;
    if (clr) begin
      act = ACT_CLEAR;
    end else if (!ce) begin
      act = ACT_HOLD;
    end else if (wrap) begin
      act = ACT_COMPLETE;
    end else begin
      act = ACT_SHIFT;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh    <= '0;
      q     <= '0;
      valid <= 1'b0;
    end else begin
      case (act)
        ACT_CLEAR: begin
          sh    <= '0;
          valid <= 1'b0;
        end
        ACT_HOLD: begin
          valid <= 1'b0;
        end
        ACT_SHIFT: begin
          sh    <= shifted;
          valid <= 1'b0;
        end
        ACT_COMPLETE: begin
          q     <= shifted;
          sh    <= '0;
          valid <= 1'b1;
        end
        default: begin
          valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sipo_deserializer_with_ce.sv
module tb_sipo_deserializer_with_ce;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         ce = 1'b0;
  logic         clr = 1'b0;
  logic         sin = 1'b0;
  logic [W-1:0] q_msb, q_lsb;
  logic         valid_msb, valid_lsb;
  logic [1:0]   cnt_msb, cnt_lsb;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference model: a list of accepted bits for the current frame.
  bit           frame[$];
  logic [W-1:0] exp_msb = '0;
  logic [W-1:0] exp_lsb = '0;
  logic         exp_valid = 1'b0;

  always #50 clk = ~clk;

  sipo_deserializer_with_ce #(.WIDTH(W), .MSB_FIRST(1)) dut_msb (
    .clk(clk), .reset_n(reset_n), .ce(ce), .clr(clr), .sin(sin),
    .q(q_msb), .valid(valid_msb), .cnt(cnt_msb)
  );

  sipo_deserializer_with_ce #(.WIDTH(W), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .reset_n(reset_n), .ce(ce), .clr(clr), .sin(sin),
    .q(q_lsb), .valid(valid_lsb), .cnt(cnt_lsb)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    frame.delete();
    exp_msb   = '0;
    exp_lsb   = '0;
    exp_valid = 1'b0;
  endtask

  task automatic model_edge(input logic c, input logic cl, input logic s);
    int unsigned wm, wl;
    exp_valid = 1'b0;
    if (cl) begin
      frame.delete();
    end else if (c) begin
      frame.push_back(s);
      if (frame.size() == W) begin
        wm = 0;
        wl = 0;
        for (int i = 0; i < W; i++) begin
          wm = wm * 2 + frame[i];
          wl = wl + (int'(frame[i]) << i);
        end
        exp_msb   = W'(wm);
        exp_lsb   = W'(wl);
        exp_valid = 1'b1;
        frame.delete();
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check_eq({tag, ".q_msb"}, 32'(q_msb), 32'(exp_msb));
    check_eq({tag, ".q_lsb"}, 32'(q_lsb), 32'(exp_lsb));
    check_eq({tag, ".valid_msb"}, 32'(valid_msb), 32'(exp_valid));
    check_eq({tag, ".valid_lsb"}, 32'(valid_lsb), 32'(exp_valid));
    check_eq({tag, ".cnt_msb"}, 32'(cnt_msb), frame.size());
    check_eq({tag, ".cnt_lsb"}, 32'(cnt_lsb), frame.size());
  endtask

  // Inputs change 1 ns after an edge, outputs are sampled 1 ns after the next.
  task automatic step(input string tag, input logic c, input logic cl, input logic s);
    ce  = c;
    clr = cl;
    sin = s;
    @(posedge clk);
    model_edge(c, cl, s);
    #1;
    compare_all(tag);
  endtask

  task automatic send_word(input string tag, input logic [3:0] w);
    for (int i = W - 1; i >= 0; i--) step(tag, 1'b1, 1'b0, w[i]);
  endtask

  task automatic async_reset(input string tag);
    #20;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_eq({tag, ".rst_q"}, 32'(q_msb), 0);
    check_eq({tag, ".rst_valid"}, 32'(valid_msb), 0);
    check_eq({tag, ".rst_cnt"}, 32'(cnt_msb), 0);
    compare_all({tag, ".rst"});
    #20;
    reset_n = 1'b1;
  endtask

  initial begin
    #25;
    compare_all("por");
    @(posedge clk);
    #20;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    compare_all("idle");

    // Reset between edges after two accepted bits.
    step("s1", 1'b1, 1'b0, 1'b1);
    step("s1", 1'b1, 1'b0, 1'b1);
    async_reset("s1");
    send_word("s1_fresh", 4'b0110);
    check_eq("s1_word", 32'(q_msb), 32'h6);

    // Single word and its one-cycle strobe.
    send_word("s2", 4'b1011);
    check_eq("s2_q", 32'(q_msb), 32'hB);
    check_eq("s2_valid", 32'(valid_msb), 1);
    check_eq("s2_cnt", 32'(cnt_msb), 0);
    step("s2_after", 1'b0, 1'b0, 1'b0);
    check_eq("s2_pulse_end", 32'(valid_msb), 0);

    // Back-to-back words.
    send_word("s3a", 4'b1011);
    check_eq("s3_q1", 32'(q_msb), 32'hB);
    send_word("s3b", 4'b0010);
    check_eq("s3_q2", 32'(q_msb), 32'h2);

    // Gated enable.
    for (int i = 0; i < W; i++) begin
      logic [3:0] pat;
      pat = 4'b0110;
      step("s4_on", 1'b1, 1'b0, pat[W-1-i]);
      step("s4_off", 1'b0, 1'b0, 1'b1);
    end
    check_eq("s4_q", 32'(q_msb), 32'h6);

    // Frame clear mid-word, then clear on the completing edge.
    step("s5", 1'b1, 1'b0, 1'b1);
    step("s5", 1'b1, 1'b0, 1'b1);
    step("s5_clr", 1'b0, 1'b1, 1'b1);
    send_word("s5_word", 4'b0101);
    check_eq("s5_q", 32'(q_msb), 32'h5);
    step("s5b", 1'b1, 1'b0, 1'b1);
    step("s5b", 1'b1, 1'b0, 1'b1);
    step("s5b", 1'b1, 1'b0, 1'b1);
    step("s5b_clr", 1'b1, 1'b1, 1'b1);
    check_eq("s5b_q_held", 32'(q_msb), 32'h5);
    check_eq("s5b_no_valid", 32'(valid_msb), 0);

    // LSB-first word 1,0,0,0.
    send_word("s6", 4'b1000);
    check_eq("s6_lsb_q", 32'(q_lsb), 32'h1);
    check_eq("s6_msb_q", 32'(q_msb), 32'h8);

    // Randomized traffic with occasional clear and reset.
    for (int n = 0; n < 600; n++) begin
      step("rnd", ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0), 1'($urandom));
      if ($urandom_range(0, 63) == 0) async_reset("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sipo_deserializer_with_ce.md
# sipo_deserializer_with_ce

Serial-in, parallel-out deserializer that assembles a single-bit input stream into WIDTH-bit words. It sits directly upstream of the PIPO_sync_4bit_register_with_ce_we stage. Its `q` bus drives that register's `d`, and its one-cycle `valid` strobe drives the register's `we`. A clock enable gates bit acceptance, and a synchronous frame-clear drops a partial word.

## Interface
- `WIDTH`, default 4: word width in bits; must be ≥ 2.
- `MSB_FIRST`, default 1: 1 places the first accepted bit in `q[WIDTH-1]`; 0 places it in `q[0]`.

- `clk`: in, 1. Rising-edge clock; the block has one clock domain.
- `reset_n`: in, 1. Asynchronous, active-low reset.
- `ce`: in, 1. Clock enable; `sin` is accepted on a rising edge only when `ce`=1.
- `clr`: in, 1. Synchronous frame restart that discards any partial word.
- `sin`: in, 1. Serial data bit.
- `q`: out, WIDTH. Last completed word; held stable between completions.
- `valid`: out, 1. One-cycle pulse marking a new `q`.
- `cnt`: out, CW = $clog2(WIDTH). Number of bits held in the current partial word.

## Operation
- Internal state:
  - `sh`: WIDTH-bit shift register.
  - `cnt`: modulo-WIDTH counter.
  - `q`: output word register.
  - `valid`: registered flag.
- Reset (`reset_n`=0) acts immediately, without a clock edge. It sets `sh`=0, `cnt`=0, `q`=0, `valid`=0. All outputs hold these values while reset is asserted.
- Per rising edge, in priority order:
  1. `clr`=1: `sh`←0, `cnt`←0, `valid`←0; `q` holds. `clr` overrides `ce`, and the `sin` of that cycle is dropped.
  2. `ce`=0: `sh`, `cnt` and `q` hold; `valid`←0.
  3. `ce`=1 and `cnt`<WIDTH-1: shift `sin` into `sh`; `cnt`←`cnt`+1; `valid`←0.
  4. `ce`=1 and `cnt`=WIDTH-1: `q`←completed word, which includes the current `sin`; `sh`←0; `cnt`←0; `valid`←1.
- Shift direction:
  - `MSB_FIRST`=1: `sh`←{`sh`[WIDTH-2:0], `sin`}.
  - `MSB_FIRST`=0: `sh`←{`sin`, `sh`[WIDTH-1:1]}.
- `cnt` wraps from WIDTH-1 to 0 with no idle cycle. A continuous `ce`=1 stream therefore yields one word every WIDTH cycles, and back-to-back words never lose a bit.
- `clr` and completion in the same cycle: `clr` wins. `q` is not updated and no `valid` pulse is produced.
- Reset asserted mid-word discards the partial word. The first accepted bit after release is bit 0 of a new word.

## Timing
- Latency: `q` and `valid` change on the same edge that accepts the WIDTH-th bit, and are visible immediately after it.
- `valid` is high for exactly one clock cycle per completed word, even if `ce` stays high.
- `valid` is never asserted in a cycle where the preceding edge saw `ce`=0, `clr`=1, or reset.
- `q` is stable whenever `valid`=1. The downstream register captures it on the next edge when it has `ce`=1 and `we`=`valid`.
- No combinational path from any input to any output; all outputs are registered.

## Structure
- Shared package/header holds:
  - the CW derivation ($clog2(WIDTH));
  - the default WIDTH=4, shared with the downstream 4-bit register so both widths match.
- The modulo-N counter is split into the sub-module `mod_n_counter` (ports `clk`, `reset_n`, `clr`, `en`, `cnt`, `wrap`). Its `wrap` output triggers word completion.
- Shift register, output register and `valid` flop live in the top module.
- Total RTL size is about 120–180 lines.

## Test plan
Scenarios 1–5 use WIDTH=4 and MSB_FIRST=1; all use a 100 ns clock period.

1. **Reset mid-run:** assert `reset_n`=0 after two accepted bits, between clock edges. Expect `q`=0000, `valid`=0 and `cnt`=0 immediately, with no clock edge. After release, the next four bits form a fresh word.
2. **Single word:** `ce`=1, `sin`=1,0,1,1 on consecutive edges. After the 4th edge expect `q`=1011, `valid`=1 for exactly one cycle, and `cnt`=0.
3. **Back-to-back words:** stream 1011 then 0010 with `ce`=1. Expect two `valid` pulses four cycles apart, with `q`=1011 then `q`=0010, and no dropped bit.
4. **Gated enable:** `ce` alternates 1/0 while `sin` presents 0,1,1,0 on the enabled edges. Expect `q`=0110 after the 4th enabled edge, and `valid` never high following a `ce`=0 edge.
5. **Frame clear:** accept bits 1,1, pulse `clr` for one cycle, then accept 0,1,0,1. Expect `q`=0101 with a single `valid` pulse, and no word containing the discarded 11. Then pulse `clr` on the completing edge of a word: `q` is unchanged and no `valid` pulse occurs.
6. **LSB-first:** with MSB_FIRST=0, send `sin`=1,0,0,0. Expect `q`=0001.
